// File: rtl/cache_sa.sv
// N-way set-associative, write-back / write-allocate cache with one word per line,
// age-based LRU replacement and saturating hit/miss counters.
module cache_sa #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int CACHE_SIZE = 32,
    parameter int BLOCK_SIZE = 4,
    parameter int WAYS       = 2,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cs,
    input  logic                  re,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  ready,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  hit,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ack,
    output logic [CNT_WIDTH-1:0]  hit_cnt,
    output logic [CNT_WIDTH-1:0]  miss_cnt
);
    localparam int SETS   = CACHE_SIZE / (BLOCK_SIZE * WAYS);
    localparam int OFF_W  = $clog2(BLOCK_SIZE);
    localparam int IDX_W  = $clog2(SETS);
    localparam int IDX_WS = (IDX_W > 0) ? IDX_W : 1;
    localparam int TAG_W  = ADDR_WIDTH - OFF_W - IDX_W;
    localparam int AGE_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [2:0] {IDLE, WB, FILL, INSTALL, RESP} state_t;

    state_t state;

    logic [DATA_WIDTH-1:0] line_data  [SETS][WAYS];
    logic [TAG_W-1:0]      line_tag   [SETS][WAYS];
    logic                  line_vld   [SETS][WAYS];
    logic                  line_dirty [SETS][WAYS];
    logic [AGE_W-1:0]      line_age   [SETS][WAYS];

    logic                  req_we;
    logic [TAG_W-1:0]      req_tag;
    logic [IDX_WS-1:0]     req_idx;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic [AGE_W-1:0]      vic;

    logic [TAG_W-1:0]      a_tag;
    logic [IDX_WS-1:0]     a_idx;
    logic                  acc;
    logic                  lk_hit;
    logic [AGE_W-1:0]      lk_way;
    logic [AGE_W-1:0]      vic_way;
    logic                  vic_inv;
    logic                  fill_done;
    logic                  touch_en;
    logic [IDX_WS-1:0]     touch_set;
    logic [AGE_W-1:0]      touch_way;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] line_addr(input logic [TAG_W-1:0] t,
                                                         input logic [IDX_WS-1:0] i);
        logic [ADDR_WIDTH-1:0] a;
        a = ADDR_WIDTH'(t) << (OFF_W + IDX_W);
        if (IDX_W > 0) a = a | (ADDR_WIDTH'(i) << OFF_W);
        return a;
    endfunction

    assign a_tag = addr[ADDR_WIDTH-1 -: TAG_W];
    if (IDX_W > 0) begin : g_idx
        assign a_idx = addr[OFF_W +: IDX_W];
    end else begin : g_no_idx
        assign a_idx = '0;
    end
    if (OFF_W > 0) begin : g_off
        logic unused_off;
        assign unused_off = ^addr[OFF_W-1:0];
    end

    assign ready     = (state == IDLE) && rst_n;
    assign acc       = cs && ready && (re ^ we);
    assign fill_done = (state == FILL) && mem_req && mem_ack;

    // Lookup and victim choice: lowest invalid way, otherwise the oldest way.
    always_comb begin
        lk_hit  = 1'b0;
        lk_way  = '0;
        vic_way = '0;
        vic_inv = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (line_vld[a_idx][w] && line_tag[a_idx][w] == a_tag) begin
                lk_hit = 1'b1;
                lk_way = AGE_W'(w);
            end
        end
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!line_vld[a_idx][w]) begin
                vic_inv = 1'b1;
                vic_way = AGE_W'(w);
            end
        end
        if (!vic_inv) begin
            for (int w = 0; w < WAYS; w++) begin
                if (line_age[a_idx][w] == AGE_W'(WAYS - 1)) vic_way = AGE_W'(w);
            end
        end
    end

    always_comb begin
        touch_en  = (acc && lk_hit) || fill_done || (state == INSTALL);
        touch_set = (state == IDLE) ? a_idx : req_idx;
        touch_way = (state == IDLE) ? lk_way : vic;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            resp_valid <= 1'b0;
            hit        <= 1'b0;
            rdata      <= '0;
            hit_cnt    <= '0;
            miss_cnt   <= '0;
            req_we     <= 1'b0;
            req_tag    <= '0;
            req_idx    <= '0;
            req_wdata  <= '0;
            vic        <= '0;
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    line_vld[s][w]   <= 1'b0;
                    line_dirty[s][w] <= 1'b0;
                    line_age[s][w]   <= AGE_W'(w);
                end
            end
        end else begin
            resp_valid <= 1'b0;
            case (state)
                IDLE: if (acc) begin
                    req_we    <= we;
                    req_tag   <= a_tag;
                    req_idx   <= a_idx;
                    req_wdata <= wdata;
                    vic       <= vic_way;
                    if (lk_hit) begin
                        resp_valid <= 1'b1;
                        hit        <= 1'b1;
                        hit_cnt    <= sat_inc(hit_cnt);
                        if (we) line_dirty[a_idx][lk_way] <= 1'b1;
                        else    rdata <= line_data[a_idx][lk_way];
                    end else begin
                        miss_cnt <= sat_inc(miss_cnt);
                        if (line_vld[a_idx][vic_way] && line_dirty[a_idx][vic_way]) begin
                            state     <= WB;
                            mem_req   <= 1'b1;
                            mem_we    <= 1'b1;
                            mem_addr  <= line_addr(line_tag[a_idx][vic_way], a_idx);
                            mem_wdata <= line_data[a_idx][vic_way];
                        end else if (we) begin
                            state <= INSTALL;
                        end else begin
                            state    <= FILL;
                            mem_req  <= 1'b1;
                            mem_we   <= 1'b0;
                            mem_addr <= line_addr(a_tag, a_idx);
                        end
                    end
                end
                // After a writeback, mem_req drops for one cycle before the fill starts.
                WB: if (mem_ack) begin
                    mem_req  <= 1'b0;
                    mem_we   <= 1'b0;
                    mem_addr <= line_addr(req_tag, req_idx);
                    state    <= req_we ? INSTALL : FILL;
                end
                FILL: begin
                    if (!mem_req) begin
                        mem_req <= 1'b1;
                    end else if (mem_ack) begin
                        mem_req                <= 1'b0;
                        rdata                  <= mem_rdata;
                        line_vld[req_idx][vic]   <= 1'b1;
                        line_dirty[req_idx][vic] <= 1'b0;
                        resp_valid             <= 1'b1;
                        hit                    <= 1'b0;
                        state                  <= RESP;
                    end
                end
                INSTALL: begin
                    line_vld[req_idx][vic]   <= 1'b1;
                    line_dirty[req_idx][vic] <= 1'b1;
                    resp_valid             <= 1'b1;
                    hit                    <= 1'b0;
                    state                  <= RESP;
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
            if (touch_en) begin
                for (int w = 0; w < WAYS; w++) begin
                    if (AGE_W'(w) == touch_way)
                        line_age[touch_set][w] <= '0;
                    else if (line_age[touch_set][w] < line_age[touch_set][touch_way])
                        line_age[touch_set][w] <= line_age[touch_set][w] + 1'b1;
                end
            end
        end
    end

    // Line payload and tags need no reset: the valid bits guard them.
    always_ff @(posedge clk) begin
        if (acc && lk_hit && we) line_data[a_idx][lk_way] <= wdata;
        if (fill_done) begin
            line_data[req_idx][vic] <= mem_rdata;
            line_tag[req_idx][vic]  <= req_tag;
        end
        if (state == INSTALL) begin
            line_data[req_idx][vic] <= req_wdata;
            line_tag[req_idx][vic]  <= req_tag;
        end
    end

endmodule

// File: tb/tb_cache_sa.sv
// Self-checking bench for cache_sa: directed sequences, a vector table and a
// randomized run against a recency-ordered behavioural cache model.
`timescale 1ns/1ps
module tb_cache_sa;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int CW = 4;
    localparam int NSETS = 4;
    localparam int NWAYS = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cs = 1'b0, re = 1'b0, we = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] wdata = '0;
    logic          ready, resp_valid, hit, mem_req, mem_we;
    logic [DW-1:0] rdata, mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic [AW-1:0] mem_addr;
    logic          mem_ack = 1'b0;
    logic [CW-1:0] hit_cnt, miss_cnt;

    always #5 clk = ~clk;

    cache_sa #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CACHE_SIZE(32), .BLOCK_SIZE(4),
               .WAYS(NWAYS), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n), .cs(cs), .re(re), .we(we), .addr(addr), .wdata(wdata),
        .ready(ready), .resp_valid(resp_valid), .rdata(rdata), .hit(hit),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt));

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // ---------------- memory side ----------------
    typedef struct { bit w; logic [AW-1:0] a; logic [DW-1:0] d; } txn_t;
    logic [DW-1:0] phys [logic [AW-1:0]];
    txn_t          log_q[$];
    int            lat = 3;
    bit            ack_en = 1'b1;

    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    initial begin : mem_model
        int cnt;
        txn_t t;
        cnt = 0;
        forever begin
            @(negedge clk);
            if (mem_ack) begin
                mem_ack = 1'b0;
            end else if (mem_req && rst_n && ack_en) begin
                cnt++;
                if (cnt >= lat) begin
                    cnt = 0;
                    mem_ack = 1'b1;
                    t.w = mem_we; t.a = mem_addr; t.d = mem_wdata;
                    log_q.push_back(t);
                    if (mem_we) phys[mem_addr] = mem_wdata;
                    else mem_rdata = phys.exists(mem_addr) ? phys[mem_addr] : init_val(mem_addr);
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // ---------------- reference model ----------------
    typedef struct { bit v; logic [AW-1:0] line; longint ts; } mline_t;
    mline_t        m [NSETS][NWAYS];
    logic [DW-1:0] arch [logic [AW-1:0]];
    longint        now;
    int            m_hits, m_miss;

    task automatic model_reset();
        for (int s = 0; s < NSETS; s++)
            for (int w = 0; w < NWAYS; w++) begin
                m[s][w].v = 1'b0; m[s][w].line = '0; m[s][w].ts = 0;
            end
        now = 0; m_hits = 0; m_miss = 0;
    endtask

    // A line hits if resident; misses fill the lowest empty way or the least recently used one.
    task automatic model_access(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                                output bit h, output logic [DW-1:0] rd);
        logic [AW-1:0] la;
        int s, way;
        la = {a[AW-1:2], 2'b00};
        s = int'(a[3:2]);
        way = -1;
        now++;
        for (int i = 0; i < NWAYS; i++) if (m[s][i].v && m[s][i].line == la) way = i;
        h = (way >= 0);
        if (h) m_hits = (m_hits < (1 << CW) - 1) ? m_hits + 1 : m_hits;
        else   m_miss = (m_miss < (1 << CW) - 1) ? m_miss + 1 : m_miss;
        if (!h) begin
            for (int i = NWAYS - 1; i >= 0; i--) if (!m[s][i].v) way = i;
            if (way < 0) begin
                way = 0;
                for (int i = 1; i < NWAYS; i++) if (m[s][i].ts < m[s][way].ts) way = i;
            end
            m[s][way].v = 1'b1;
            m[s][way].line = la;
        end
        m[s][way].ts = now;
        if (w) arch[la] = d;
        rd = arch.exists(la) ? arch[la] : init_val(la);
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic do_reset();
        cs = 1'b0; re = 1'b0; we = 1'b0; ack_en = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        log_q.delete();
        @(negedge clk);
    endtask

    // Issue one request from a negedge and wait (bounded) for its response.
    task automatic do_req(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          output bit h, output logic [DW-1:0] rd, output int lat_c);
        int t;
        t = 0;
        while (!ready && t < 200) begin @(negedge clk); t++; end
        cs = 1'b1; re = !w; we = w; addr = a; wdata = d;
        @(negedge clk);
        cs = 1'b0; re = 1'b0; we = 1'b0;
        lat_c = 1;
        while (!resp_valid && lat_c < 300) begin @(negedge clk); lat_c++; end
        check("resp_seen", resp_valid, 1'b1);
        h = hit; rd = rdata;
    endtask

    typedef struct {
        bit            w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        bit            exp_hit;
        bit            chk_rd;
        logic [DW-1:0] exp_rd;
    } vec_t;

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t          tv[5];
        bit            h;
        logic [DW-1:0] rd;
        int            lc, t;
        bit            ok;

        tv[0] = '{w: 1'b1, a: 32'h00, d: 32'h12, exp_hit: 1'b0, chk_rd: 1'b0, exp_rd: 32'h0};
        tv[1] = '{w: 1'b1, a: 32'h10, d: 32'h99, exp_hit: 1'b0, chk_rd: 1'b0, exp_rd: 32'h0};
        tv[2] = '{w: 1'b0, a: 32'h00, d: 32'h0,  exp_hit: 1'b1, chk_rd: 1'b1, exp_rd: 32'h12};
        tv[3] = '{w: 1'b0, a: 32'h20, d: 32'h0,  exp_hit: 1'b0, chk_rd: 1'b1, exp_rd: 32'hA5};
        tv[4] = '{w: 1'b0, a: 32'h00, d: 32'h0,  exp_hit: 1'b1, chk_rd: 1'b1, exp_rd: 32'h12};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_ready_low", ready, 1'b0);
        check("rst_mem_req", mem_req, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready", ready, 1'b1);
        check("rst_resp_valid", resp_valid, 1'b0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_hit_cnt", hit_cnt, 0);
        check("rst_miss_cnt", miss_cnt, 0);

        // 1. Clean read miss then reread hit
        phys[32'h20] = 32'hA5;
        cs = 1'b1; re = 1'b1; addr = 32'h20;
        @(negedge clk);
        cs = 1'b0; re = 1'b0;
        check("t1_mem_req", mem_req, 1'b1);
        check("t1_mem_we", mem_we, 1'b0);
        check("t1_mem_addr", mem_addr, 32'h20);
        check("t1_ready_busy", ready, 1'b0);
        t = 0;
        while (!resp_valid && t < 100) begin @(negedge clk); t++; end
        check("t1_resp", resp_valid, 1'b1);
        check("t1_hit", hit, 1'b0);
        check("t1_rdata", rdata, 32'hA5);
        check("t1_miss_cnt", miss_cnt, 1);
        log_q.delete();
        do_req(1'b0, 32'h20, '0, h, rd, lc);
        check("t1_rehit", h, 1'b1);
        check("t1_rehit_rdata", rd, 32'hA5);
        check("t1_rehit_latency", lc, 1);
        check("t1_no_mem_req", mem_req, 1'b0);
        check("t1_hit_cnt", hit_cnt, 1);

        // 3. Illegal re=we=1 request
        cs = 1'b1; re = 1'b1; we = 1'b1; addr = 32'h00;
        @(negedge clk);
        cs = 1'b0; re = 1'b0; we = 1'b0;
        check("t3_ready", ready, 1'b1);
        check("t3_resp", resp_valid, 1'b0);
        @(negedge clk);
        check("t3_resp_late", resp_valid, 1'b0);
        check("t3_hit_cnt", hit_cnt, 1);
        check("t3_miss_cnt", miss_cnt, 1);
        check("t3_mem_req", mem_req, 1'b0);

        // 2. Table: dirty eviction ordering
        do_reset();
        for (int i = 0; i < 5; i++) begin
            do_req(tv[i].w, tv[i].a, tv[i].d, h, rd, lc);
            check($sformatf("t2_vec%0d_hit", i), h, tv[i].exp_hit);
            if (tv[i].chk_rd) check($sformatf("t2_vec%0d_rdata", i), rd, tv[i].exp_rd);
        end
        check("t2_txn_count", log_q.size(), 2);
        if (log_q.size() == 2) begin
            check("t2_wb_we", log_q[0].w, 1'b1);
            check("t2_wb_addr", log_q[0].a, 32'h10);
            check("t2_wb_data", log_q[0].d, 32'h99);
            check("t2_fill_we", log_q[1].w, 1'b0);
            check("t2_fill_addr", log_q[1].a, 32'h20);
        end

        // 4. Stalled fill with extra requests dropped
        do_reset();
        ack_en = 1'b0;
        cs = 1'b1; re = 1'b1; addr = 32'h40;
        @(negedge clk);
        ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cs = i[0]; re = 1'b1; addr = 32'h44 + 32'(i * 4);
            @(negedge clk);
            if (!(mem_req === 1'b1 && mem_addr === 32'h40 && mem_we === 1'b0 && ready === 1'b0))
                ok = 1'b0;
        end
        cs = 1'b0; re = 1'b0;
        check("t4_fill_held", ok, 1'b1);
        ack_en = 1'b1;
        t = 0;
        while (!resp_valid && t < 100) begin @(negedge clk); t++; end
        check("t4_resp", resp_valid, 1'b1);
        check("t4_rdata", rdata, init_val(32'h40));
        ok = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (resp_valid !== 1'b0 || mem_req !== 1'b0) ok = 1'b0;
        end
        check("t4_dropped_quiet", ok, 1'b1);
        check("t4_miss_cnt", miss_cnt, 1);
        check("t4_hit_cnt", hit_cnt, 0);

        // 5. Reset during FILL
        do_reset();
        ack_en = 1'b0;
        cs = 1'b1; re = 1'b1; addr = 32'h20;
        @(negedge clk);
        cs = 1'b0; re = 1'b0;
        @(negedge clk);
        check("t5_mem_req_before", mem_req, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("t5_mem_req_async", mem_req, 1'b0);
        check("t5_ready_in_reset", ready, 1'b0);
        ok = 1'b1;
        repeat (2) begin @(negedge clk); if (resp_valid !== 1'b0) ok = 1'b0; end
        rst_n = 1'b1;
        ack_en = 1'b1;
        repeat (3) begin @(negedge clk); if (resp_valid !== 1'b0 || mem_req !== 1'b0) ok = 1'b0; end
        check("t5_no_resp", ok, 1'b1);
        do_req(1'b0, 32'h20, '0, h, rd, lc);
        check("t5_reread_miss", h, 1'b0);
        check("t5_reread_rdata", rd, 32'hA5);
        check("t5_miss_cnt", miss_cnt, 1);

        // 6. Hit counter saturation
        do_reset();
        do_req(1'b0, 32'h24, '0, h, rd, lc);
        for (int i = 0; i < 20; i++) begin
            do_req(1'b0, 32'h24, '0, h, rd, lc);
            if (i == 13) check("t6_hit_cnt_14", hit_cnt, 14);
        end
        check("t6_last_hit", h, 1'b1);
        check("t6_hit_cnt_sat", hit_cnt, 15);
        check("t6_miss_cnt", miss_cnt, 1);

        // Randomized traffic against the reference model
        do_reset();
        phys.delete();
        arch.delete();
        model_reset();
        for (int i = 0; i < 300; i++) begin
            bit            w, eh;
            logic [AW-1:0] a;
            logic [DW-1:0] d, er;
            w = 1'($urandom_range(0, 1));
            a = (32'($urandom_range(0, 5)) << 4) | (32'($urandom_range(0, 3)) << 2)
                | 32'($urandom_range(0, 3));
            d = $urandom;
            lat = $urandom_range(1, 4);
            model_access(w, a, d, eh, er);
            do_req(w, a, d, h, rd, lc);
            check($sformatf("rnd%0d_hit a=%0h", i, a), h, eh);
            if (!w) check($sformatf("rnd%0d_rdata a=%0h", i, a), rd, er);
            if (eh) check($sformatf("rnd%0d_hit_latency", i), lc, 1);
        end
        @(negedge clk);
        check("rnd_hit_cnt", hit_cnt, m_hits);
        check("rnd_miss_cnt", miss_cnt, m_miss);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
